// File: rtl/uart_pkg.sv
// Shared definitions for the UART APB controller.
//   - register addresses
//   - APB-side FSM state and captured-operation enums
//   - parity encoding and configuration reset values
package uart_pkg;

  localparam int unsigned AddrTransData   = 32'h00;
  localparam int unsigned AddrRecvData    = 32'h04;
  localparam int unsigned AddrBaudConfig  = 32'h08;
  localparam int unsigned AddrFrameConfig = 32'h0C;
  localparam int unsigned AddrParConfig   = 32'h10;
  localparam int unsigned AddrStopConfig  = 32'h14;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  typedef enum logic [2:0] {OpNone, OpTx, OpRx, OpCfgWr, OpCfgRd, OpMulti} op_e;

  typedef enum logic [1:0] {
    ParityNone = 2'd0,
    ParityOdd  = 2'd1,
    ParityEven = 2'd2,
    ParityRsvd = 2'd3
  } parity_e;

  localparam logic [15:0] BaudDivRst   = 16'd434;
  localparam logic [3:0]  FrameLenRst  = 4'd8;
  localparam logic [1:0]  ParityRst    = ParityNone;
  localparam logic [1:0]  StopBitsRst  = 2'd1;

  // Collapse the four detect strobes into one operation; several at once is illegal.
  function automatic op_e decode_op(input logic tx, input logic rx, input logic cw,
                                    input logic cr);
    logic [2:0] n;
    op_e        op;
    n = {2'b0, tx} + {2'b0, rx} + {2'b0, cw} + {2'b0, cr};
    if (n > 3'd1)  op = OpMulti;
    else if (tx)   op = OpTx;
    else if (rx)   op = OpRx;
    else if (cw)   op = OpCfgWr;
    else if (cr)   op = OpCfgRd;
    else           op = OpNone;
    return op;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// Ports: clk_i/rst_i (sync, active-high), push_i/wdata_i write side,
//        pop_i/rdata_o read side (rdata_o shows the head entry), full_o/empty_o flags.
module uart_tx_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   cnt_q;
  logic            push_ok, pop_ok;

  assign full_o  = (cnt_q == (PtrW + 1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (PtrW + 1)'(push_ok) - (PtrW + 1)'(pop_ok);
    end
  end

endmodule

// File: rtl/uart_apb_ctrl.sv
// APB-facing control block for a UART.
// Ports: PCLK/PRESET (sync, active-high); TX/RX/config detect strobes with
//        config_address/write_data; read_data/ready/error APB response;
//        tx_start/tx_data/tx_busy transmitter handshake; rx_valid/rx_data/rx_err
//        receiver input; baud_div/frame_len/parity_mode/stop_bits configuration.
// A detect seen in IDLE is captured, executed in ACCESS and answered in RESP.
module uart_apb_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TX_DEPTH   = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  TX_detect,
  input  logic                  RX_detect,
  input  logic                  config_write_detect,
  input  logic                  config_read_detect,
  input  logic [ADDR_WIDTH-1:0] config_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  ready,
  output logic                  error,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic [1:0]            rx_err,
  output logic [15:0]           baud_div,
  output logic [3:0]            frame_len,
  output logic [1:0]            parity_mode,
  output logic [1:0]            stop_bits
);

  state_e                state_q;
  op_e                   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wdata_q;
  logic                  ready_q, error_q, tx_start_q;
  logic [DATA_WIDTH-1:0] read_data_q;
  logic [7:0]            tx_data_q;
  logic                  rx_valid_q, rx_ovr_q;
  logic [1:0]            rx_err_q;
  logic [7:0]            rx_data_q;
  logic [15:0]           baud_q;
  logic [3:0]            frame_q;
  logic [1:0]            parity_q, stop_q;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]            fifo_rdata;
  logic [3:0]            cfg_sel;
  logic                  cfg_val_ok, cfg_hit, cfg_wr_ok, rx_consume, in_access;
  logic [DATA_WIDTH-1:0] cfg_rd, resp_data;
  logic                  resp_err;
  logic                  unused_wdata;

  assign unused_wdata = ^write_data[DATA_WIDTH-1:16];

  assign in_access  = (state_q == StAccess);
  assign fifo_push  = in_access && (op_q == OpTx) && !fifo_full;
  // Pop only every other cycle so each frame gets a distinct one-cycle start pulse.
  assign fifo_pop   = !fifo_empty && !tx_busy && !tx_start_q;
  assign rx_consume = in_access && (op_q == OpRx) && rx_valid_q;

  uart_tx_fifo #(
    .Depth (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .push_i  (fifo_push),
    .wdata_i (write_data_q_byte()),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  function automatic logic [7:0] write_data_q_byte();
    return wdata_q[7:0];
  endfunction

  always_comb begin
    cfg_sel    = '0;
    cfg_rd     = '0;
    cfg_val_ok = 1'b0;
    case (addr_q)
      ADDR_WIDTH'(AddrBaudConfig): begin
        cfg_sel[0]   = 1'b1;
        cfg_rd[15:0] = baud_q;
        cfg_val_ok   = (wdata_q != 16'd0);
      end
      ADDR_WIDTH'(AddrFrameConfig): begin
        cfg_sel[1]  = 1'b1;
        cfg_rd[3:0] = frame_q;
        cfg_val_ok  = (wdata_q[3:0] >= 4'd5) && (wdata_q[3:0] <= 4'd9);
      end
      ADDR_WIDTH'(AddrParConfig): begin
        cfg_sel[2]  = 1'b1;
        cfg_rd[1:0] = parity_q;
        cfg_val_ok  = (wdata_q[1:0] != ParityRsvd);
      end
      ADDR_WIDTH'(AddrStopConfig): begin
        cfg_sel[3]  = 1'b1;
        cfg_rd[1:0] = stop_q;
        cfg_val_ok  = (wdata_q[1:0] == 2'd1) || (wdata_q[1:0] == 2'd2);
      end
      default: ;
    endcase
  end

  assign cfg_hit   = |cfg_sel;
  // Reconfiguring while bytes are queued or on the wire would corrupt frames.
  assign cfg_wr_ok = cfg_hit && cfg_val_ok && fifo_empty && !tx_busy;

  always_comb begin
    resp_err  = 1'b0;
    resp_data = '0;
    case (op_q)
      OpTx:    resp_err = fifo_full;
      OpRx: begin
        if (rx_valid_q) resp_data[10:0] = {rx_ovr_q, rx_err_q, rx_data_q};
        else            resp_err = 1'b1;
      end
      OpCfgWr: resp_err = !cfg_wr_ok;
      OpCfgRd: begin
        if (cfg_hit) resp_data = cfg_rd;
        else         resp_err = 1'b1;
      end
      default: resp_err = 1'b1;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= StIdle;
      op_q        <= OpNone;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      read_data_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ovr_q    <= 1'b0;
      rx_err_q    <= '0;
      rx_data_q   <= '0;
      baud_q      <= BaudDivRst;
      frame_q     <= FrameLenRst;
      parity_q    <= ParityRst;
      stop_q      <= StopBitsRst;
    end else begin
      tx_start_q <= fifo_pop;
      if (fifo_pop) tx_data_q <= fifo_rdata;

      // A byte arriving during a consuming read replaces the one being returned.
      if (rx_valid) begin
        rx_valid_q <= 1'b1;
        rx_ovr_q   <= rx_consume ? 1'b0 : (rx_ovr_q | rx_valid_q);
        rx_err_q   <= rx_err;
        rx_data_q  <= rx_data;
      end else if (rx_consume) begin
        rx_valid_q <= 1'b0;
        rx_ovr_q   <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (TX_detect || RX_detect || config_write_detect || config_read_detect) begin
            op_q    <= decode_op(TX_detect, RX_detect, config_write_detect,
                                 config_read_detect);
            addr_q  <= config_address;
            wdata_q <= write_data[15:0];
            state_q <= StAccess;
          end
        end
        StAccess: begin
          state_q     <= StResp;
          ready_q     <= 1'b1;
          error_q     <= resp_err;
          read_data_q <= resp_data;
          if ((op_q == OpCfgWr) && cfg_wr_ok) begin
            if (cfg_sel[0]) baud_q   <= wdata_q;
            if (cfg_sel[1]) frame_q  <= wdata_q[3:0];
            if (cfg_sel[2]) parity_q <= wdata_q[1:0];
            if (cfg_sel[3]) stop_q   <= wdata_q[1:0];
          end
        end
        StResp: begin
          state_q     <= StIdle;
          ready_q     <= 1'b0;
          error_q     <= 1'b0;
          read_data_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign read_data   = read_data_q;
  assign ready       = ready_q;
  assign error       = error_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign baud_div    = baud_q;
  assign frame_len   = frame_q;
  assign parity_mode = parity_q;
  assign stop_bits   = stop_q;

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Randomised scoreboard bench for uart_apb_ctrl: a transaction-level model predicts
// each APB response and each launched byte; monitors compare what the DUT presents.
module tb_uart_apb_ctrl;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned TXD = 4;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          TX_detect = 1'b0, RX_detect = 1'b0;
  logic          config_write_detect = 1'b0, config_read_detect = 1'b0;
  logic [AW-1:0] config_address = '0;
  logic [DW-1:0] write_data = '0;
  logic [DW-1:0] read_data;
  logic          ready, error, tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic [1:0]    rx_err = '0;
  logic [15:0]   baud_div;
  logic [3:0]    frame_len;
  logic [1:0]    parity_mode, stop_bits;

  always #5 PCLK = ~PCLK;

  uart_apb_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TX_DEPTH   (TXD)
  ) dut (
    .PCLK                (PCLK),
    .PRESET              (PRESET),
    .TX_detect           (TX_detect),
    .RX_detect           (RX_detect),
    .config_write_detect (config_write_detect),
    .config_read_detect  (config_read_detect),
    .config_address      (config_address),
    .write_data          (write_data),
    .read_data           (read_data),
    .ready               (ready),
    .error               (error),
    .tx_start            (tx_start),
    .tx_data             (tx_data),
    .tx_busy             (tx_busy),
    .rx_valid            (rx_valid),
    .rx_data             (rx_data),
    .rx_err              (rx_err),
    .baud_div            (baud_div),
    .frame_len           (frame_len),
    .parity_mode         (parity_mode),
    .stop_bits           (stop_bits)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  int   checks = 0;
  int   failures = 0;
  rsp_t exp_rsp[$];
  logic [7:0] exp_tx[$];

  // Reference model state
  int          fifo_cnt;
  bit          busy_m;
  bit          rxm_vld, rxm_ovr;
  logic [1:0]  rxm_e;
  logic [7:0]  rxm_d;
  logic [15:0] m_baud;
  logic [3:0]  m_frame;
  logic [1:0]  m_par, m_stop;

  localparam logic [31:0] CfgAddr [4] = '{32'h08, 32'h0C, 32'h10, 32'h14};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fifo_cnt = 0;
    rxm_vld  = 0;
    rxm_ovr  = 0;
    rxm_e    = '0;
    rxm_d    = '0;
    m_baud   = 16'd434;
    m_frame  = 4'd8;
    m_par    = 2'd0;
    m_stop   = 2'd1;
    exp_tx.delete();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_baud", 32'(baud_div), 434);
    chk("rst_frame", 32'(frame_len), 8);
    chk("rst_parity", 32'(parity_mode), 0);
    chk("rst_stop", 32'(stop_bits), 1);
  endtask

  // Response monitor: every cycle with ready high must match the oldest prediction.
  initial begin
    rsp_t e;
    forever begin
      @(negedge PCLK);
      if (!PRESET) begin
        if (ready) begin
          if (exp_rsp.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready actual=1 required=0 at %0t", $time);
          end else begin
            e = exp_rsp.pop_front();
            chk("rsp_error", 32'(error), 32'(e.err));
            chk("rsp_read_data", read_data, e.data);
          end
        end else begin
          chk("idle_error", 32'(error), 0);
          chk("idle_read_data", read_data, 0);
        end
      end
    end
  end

  // Transmit monitor: each start pulse must carry the next accepted byte.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge PCLK);
      if (!PRESET && tx_start) begin
        if (exp_tx.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_tx_start actual=0x%0h required=none at %0t",
                   tx_data, $time);
        end else begin
          b = exp_tx.pop_front();
          chk("tx_data", 32'(tx_data), 32'(b));
        end
      end
    end
  end

  function automatic bit cfg_value_ok(input logic [31:0] addr, input logic [31:0] v);
    case (addr)
      32'h08:  return v[15:0] != 0;
      32'h0C:  return (v[3:0] >= 5) && (v[3:0] <= 9);
      32'h10:  return v[1:0] != 3;
      32'h14:  return (v[1:0] == 1) || (v[1:0] == 2);
      default: return 0;
    endcase
  endfunction

  // kind: 0 TX write, 1 RX read, 2 config write, 3 config read, 4 several detects (mask)
  task automatic txn(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] mask, input bit conc, input logic [7:0] cd,
                     input logic [1:0] ce);
    rsp_t e;
    int   n;
    e = '0;
    case (kind)
      0: begin
        if (fifo_cnt == TXD) e.err = 1;
        else begin
          fifo_cnt++;
          exp_tx.push_back(wd[7:0]);
        end
      end
      1: begin
        if (rxm_vld) begin
          e.data = {21'b0, rxm_ovr, rxm_e, rxm_d};
          rxm_vld = 0;
          rxm_ovr = 0;
        end else e.err = 1;
        if (conc) begin
          rxm_vld = 1;
          rxm_ovr = 0;
          rxm_e   = ce;
          rxm_d   = cd;
        end
      end
      2: begin
        if (cfg_value_ok(addr, wd) && fifo_cnt == 0 && !busy_m) begin
          case (addr)
            32'h08:  m_baud  = wd[15:0];
            32'h0C:  m_frame = wd[3:0];
            32'h10:  m_par   = wd[1:0];
            default: m_stop  = wd[1:0];
          endcase
        end else e.err = 1;
      end
      3: begin
        case (addr)
          32'h08:  e.data = 32'(m_baud);
          32'h0C:  e.data = 32'(m_frame);
          32'h10:  e.data = 32'(m_par);
          default: e.data = 32'(m_stop);
        endcase
      end
      default: e.err = 1;
    endcase
    exp_rsp.push_back(e);

    config_address = addr;
    write_data     = wd;
    case (kind)
      0:       TX_detect = 1;
      1:       RX_detect = 1;
      2:       config_write_detect = 1;
      3:       config_read_detect = 1;
      default: {TX_detect, RX_detect, config_write_detect, config_read_detect} = mask;
    endcase
    @(posedge PCLK);
    #1;
    {TX_detect, RX_detect, config_write_detect, config_read_detect} = '0;
    if (conc) begin
      rx_valid = 1;
      rx_data  = cd;
      rx_err   = ce;
    end
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!ready && n < 8);
    rx_valid = 0;
    chk("ready_latency", n, 2);
    @(posedge PCLK);
    #1;
    if (!busy_m) fifo_cnt = 0;
    chk("cfg_outputs", {8'b0, baud_div, frame_len, parity_mode, stop_bits},
        {8'b0, m_baud, m_frame, m_par, m_stop});
  endtask

  task automatic rx_pulse(input logic [7:0] d, input logic [1:0] e);
    rxm_ovr  = rxm_ovr | rxm_vld;
    rxm_vld  = 1;
    rxm_d    = d;
    rxm_e    = e;
    rx_valid = 1;
    rx_data  = d;
    rx_err   = e;
    @(posedge PCLK);
    #1;
    rx_valid = 0;
  endtask

  // Dropping busy lets every queued byte go out before the next access.
  task automatic set_busy(input bit b);
    busy_m  = b;
    tx_busy = b;
    if (!b) begin
      repeat (2 * TXD + 4) @(posedge PCLK);
      #1;
      fifo_cnt = 0;
    end else begin
      @(posedge PCLK);
      #1;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          r, idx;
    logic [3:0]  m;
    logic [31:0] v;
    busy_m = 0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    chk_reset_outputs();
    PRESET = 0;
    @(posedge PCLK);
    #1;

    // Single TX byte goes straight out
    txn(0, 32'h0, 32'h0000_00A5, '0, 0, '0, '0);
    repeat (3) @(posedge PCLK);
    #1;
    chk("tx_a5_sent", exp_tx.size(), 0);

    // Fill while busy: fifth write overflows, then four bytes drain in order
    set_busy(1);
    for (int i = 0; i < 5; i++) txn(0, 32'h0, 32'(8'h10 + i), '0, 0, '0, '0);
    set_busy(0);
    chk("fifo_drained", exp_tx.size(), 0);

    // Overrun then read, then empty read
    rx_pulse(8'h11, 2'b00);
    rx_pulse(8'h22, 2'b00);
    txn(1, 32'h4, '0, '0, 0, '0, '0);
    txn(1, 32'h4, '0, '0, 0, '0, '0);

    // Byte arriving during the consuming read
    rx_pulse(8'h33, 2'b01);
    txn(1, 32'h4, '0, '0, 1, 8'h44, 2'b10);
    txn(1, 32'h4, '0, '0, 0, '0, '0);

    // Config legality
    txn(2, 32'h08, 32'h0, '0, 0, '0, '0);
    txn(2, 32'h0C, 32'd10, '0, 0, '0, '0);
    txn(2, 32'h10, 32'd2, '0, 0, '0, '0);
    txn(3, 32'h10, '0, '0, 0, '0, '0);

    // Multiple detects at once
    txn(4, 32'h08, 32'h5, 4'b1010, 0, '0, '0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) rx_pulse(8'($urandom), 2'($urandom));
      else if (r < 17) set_busy(!busy_m);
      else if (r < 45) txn(0, 32'h0, $urandom, '0, 0, '0, '0);
      else if (r < 60) txn(1, 32'h4, '0, '0, 0, '0, '0);
      else if (r < 65) txn(1, 32'h4, '0, '0, 1, 8'($urandom), 2'($urandom));
      else if (r < 85) begin
        idx = $urandom_range(0, 3);
        case (idx)
          0:       v = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(1, 65535));
          1:       v = 32'($urandom_range(0, 15));
          default: v = 32'($urandom_range(0, 3));
        endcase
        txn(2, CfgAddr[idx], v, '0, 0, '0, '0);
      end else if (r < 95) begin
        idx = $urandom_range(0, 3);
        txn(3, CfgAddr[idx], '0, '0, 0, '0, '0);
      end else begin
        do m = 4'($urandom); while (($countones(m)) < 2);
        txn(4, CfgAddr[$urandom_range(0, 3)], $urandom, m, 0, '0, '0);
      end
    end

    // Reset in the middle of an access with a full FIFO
    set_busy(0);
    set_busy(1);
    for (int i = 0; i < 4; i++) txn(0, 32'h0, 32'(8'hC0 + i), '0, 0, '0, '0);
    write_data = 32'hEE;
    TX_detect  = 1;
    @(posedge PCLK);
    #1;
    TX_detect = 0;
    PRESET    = 1;
    @(posedge PCLK);
    #1;
    chk_reset_outputs();
    model_reset();
    PRESET = 0;
    set_busy(0);
    txn(2, 32'h10, 32'd1, '0, 0, '0, '0);
    set_busy(1);
    for (int i = 0; i < 5; i++) txn(0, 32'h0, 32'(8'h70 + i), '0, 0, '0, '0);
    set_busy(0);

    repeat (4) @(posedge PCLK);
    #1;
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
